tex_column_sequencer: RTL

Sequences one ray column at a time through the texture lookup unit and writes the finished column into the frame buffer. For each accepted column descriptor it walks vcount 0..SCREEN_HEIGHT-1 top to bottom. It writes ceiling colour above the wall slice, textured pixels inside it (one texture request per row), and floor colour below it. It sits between the DDA/column FIFO and the texture unit plus the frame-buffer BRAM write port.

---
 rtl/raycast_pkg.sv | 22 ++
 rtl/tex_column_sequencer_if.sv | 67 ++++++
 rtl/req_watchdog.sv | 40 ++++
 rtl/tex_column_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/raycast_pkg.sv
// Shared constants and types for the ray-cast column path.
// Holds screen geometry defaults, fill colours and the sequencer state enum.
package raycast_pkg;

    localparam int          DEF_SCREEN_WIDTH   = 320;
    localparam int          DEF_SCREEN_HEIGHT  = 180;
    localparam logic [7:0]  DEF_CEIL_COLOR     = 8'h10;
    localparam logic [7:0]  DEF_FLOOR_COLOR    = 8'h20;
    localparam int          DEF_TIMEOUT_CYCLES = 64;
    localparam int          FB_ADDR_W          = 16;

    typedef enum logic [2:0] {
        IDLE,
        CEIL,
        REQ,
        WAIT,
        GAP,
        FLOOR,
        DONE
    } seq_state_t;

endpackage

// File: rtl/tex_column_sequencer_if.sv
// Bundle between the column sequencer and its neighbours: column FIFO
// descriptor handshake, texture-unit request/response and frame-buffer
// write port. Modport master is the sequencer's view, slave the
// surroundings'. With TEX_TIMEOUT_EN defined a sticky tex_timeout_out is added.
interface tex_column_sequencer_if;
    import raycast_pkg::*;

    logic                 col_valid_in;
    logic                 col_ready_out;
    logic [8:0]           hcount_in;
    logic [9:0]           drawstart_in;
    logic [7:0]           lineheight_in;
    logic [15:0]          wallX_in;
    logic [3:0]           texture_in;

    logic                 valid_req_out;
    logic [7:0]           vcount_ray_out;
    logic [15:0]          wallX_out;
    logic [7:0]           lineheight_out;
    logic [9:0]           drawstart_out;
    logic [3:0]           texture_out;
    logic [7:0]           tex_pixel_in;
    logic                 valid_tex_in;

    logic [FB_ADDR_W-1:0] fb_addr_out;
    logic [7:0]           fb_data_out;
    logic                 fb_we_out;
    logic                 col_done_out;
`ifdef TEX_TIMEOUT_EN
    logic                 tex_timeout_out;

    modport master (
        input  col_valid_in, hcount_in, drawstart_in, lineheight_in,
        input  wallX_in, texture_in, tex_pixel_in, valid_tex_in,
        output col_ready_out, valid_req_out, vcount_ray_out,
        output wallX_out, lineheight_out, drawstart_out, texture_out,
        output fb_addr_out, fb_data_out, fb_we_out, col_done_out,
        output tex_timeout_out
    );

    modport slave (
        output col_valid_in, hcount_in, drawstart_in, lineheight_in,
        output wallX_in, texture_in, tex_pixel_in, valid_tex_in,
        input  col_ready_out, valid_req_out, vcount_ray_out,
        input  wallX_out, lineheight_out, drawstart_out, texture_out,
        input  fb_addr_out, fb_data_out, fb_we_out, col_done_out,
        input  tex_timeout_out
    );
`else
    modport master (
        input  col_valid_in, hcount_in, drawstart_in, lineheight_in,
        input  wallX_in, texture_in, tex_pixel_in, valid_tex_in,
        output col_ready_out, valid_req_out, vcount_ray_out,
        output wallX_out, lineheight_out, drawstart_out, texture_out,
        output fb_addr_out, fb_data_out, fb_we_out, col_done_out
    );

    modport slave (
        output col_valid_in, hcount_in, drawstart_in, lineheight_in,
        output wallX_in, texture_in, tex_pixel_in, valid_tex_in,
        input  col_ready_out, valid_req_out, vcount_ray_out,
        input  wallX_out, lineheight_out, drawstart_out, texture_out,
        input  fb_addr_out, fb_data_out, fb_we_out, col_done_out
    );
`endif

endinterface

// File: rtl/req_watchdog.sv
// Texture-request watchdog (only built with TEX_TIMEOUT_EN): counts WAIT
// cycles since the last REQ and flags expiry. Ports: clk, rst_n, clear_in, count_en_in, expired_out.
`ifdef TEX_TIMEOUT_EN
module req_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_in,
    input  logic count_en_in,
    output logic expired_out
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Fires on the LIMIT-th consecutive waiting cycle.
    assign expired_out = count_en_in && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_in) begin
            cnt_d = '0;
        end else if (count_en_in && !expired_out) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/tex_column_sequencer.sv
// Walks one ray column top to bottom: ceiling fill, one texture lookup per
// wall row, floor fill; one registered frame-buffer write per row.
// Ports: pixel_clk_in, rst_n_in (async active-low), io (master modport).
// Optional TEX_TIMEOUT_EN adds a texture-response watchdog and tex_timeout_out.
module tex_column_sequencer
    import raycast_pkg::*;
#(
    parameter int         SCREEN_WIDTH   = DEF_SCREEN_WIDTH,
    parameter int         SCREEN_HEIGHT  = DEF_SCREEN_HEIGHT,
    parameter logic [7:0] CEIL_COLOR     = DEF_CEIL_COLOR,
    parameter logic [7:0] FLOOR_COLOR    = DEF_FLOOR_COLOR
`ifdef TEX_TIMEOUT_EN
   ,parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic pixel_clk_in,
    input  logic rst_n_in,
    tex_column_sequencer_if.master io
);

    localparam logic [7:0]           H8   = 8'(SCREEN_HEIGHT);
    localparam logic [FB_ADDR_W-1:0] WSTR = FB_ADDR_W'(SCREEN_WIDTH);

    seq_state_t           state_q, state_d;
    logic [7:0]           vcount_q, vcount_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]           ds_q, ds_d;
    logic [7:0]           de_q, de_d;
    logic [15:0]          wallx_q, wallx_d;
    logic [7:0]           lh_q, lh_d;
    logic [9:0]           dstart_q, dstart_d;
    logic [3:0]           tex_q, tex_d;
    logic                 fb_we_q, fb_we_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]           fb_data_q, fb_data_d;

    logic [7:0]  ds_c;
    logic [10:0] sum_c;
    logic [7:0]  de_c;
    logic        tex_hit;
    logic [7:0]  tex_data;

    // Clamp wall bounds to the screen; sum kept 11 bits wide.
    assign ds_c  = (io.drawstart_in > 10'(SCREEN_HEIGHT)) ? H8
                 : io.drawstart_in[7:0];
    assign sum_c = {1'b0, io.drawstart_in} + {3'b000, io.lineheight_in};
    assign de_c  = (sum_c > 11'(SCREEN_HEIGHT)) ? H8 : sum_c[7:0];

`ifdef TEX_TIMEOUT_EN
    logic wd_expired;
    logic timeout_q, timeout_d;

    req_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_req_watchdog (
        .clk        (pixel_clk_in),
        .rst_n      (rst_n_in),
        .clear_in   (state_q == REQ),
        .count_en_in(state_q == WAIT),
        .expired_out(wd_expired)
    );

    // A real pulse wins over a same-cycle expiry.
    assign tex_hit  = io.valid_tex_in | wd_expired;
    assign tex_data = io.valid_tex_in ? io.tex_pixel_in
                    : (CEIL_COLOR ^ 8'hFF);

    always_comb begin
        timeout_d = timeout_q;
        if (state_q == WAIT && wd_expired && !io.valid_tex_in) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign io.tex_timeout_out = timeout_q;
`else
    assign tex_hit  = io.valid_tex_in;
    assign tex_data = io.tex_pixel_in;
`endif

    always_comb begin
        state_d   = state_q;
        vcount_d  = vcount_q;
        addr_d    = addr_q;
        ds_d      = ds_q;
        de_d      = de_q;
        wallx_d   = wallx_q;
        lh_d      = lh_q;
        dstart_d  = dstart_q;
        tex_d     = tex_q;
        fb_we_d   = 1'b0;
        fb_addr_d = '0;
        fb_data_d = '0;

        unique case (state_q)
            IDLE: begin
                if (io.col_valid_in) begin
                    ds_d     = ds_c;
                    de_d     = de_c;
                    wallx_d  = io.wallX_in;
                    lh_d     = io.lineheight_in;
                    dstart_d = io.drawstart_in;
                    tex_d    = io.texture_in;
                    vcount_d = '0;
                    addr_d   = FB_ADDR_W'(io.hcount_in);
                    state_d  = CEIL;
                end
            end
            CEIL: begin
                if (vcount_q < ds_q) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = addr_q;
                    fb_data_d = CEIL_COLOR;
                    vcount_d  = vcount_q + 8'd1;
                    addr_d    = addr_q + WSTR;
                end else if (vcount_q < de_q) begin
                    state_d = REQ;
                end else begin
                    state_d = FLOOR;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tex_hit) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = addr_q;
                    fb_data_d = tex_data;
                    vcount_d  = vcount_q + 8'd1;
                    addr_d    = addr_q + WSTR;
                    if (({1'b0, vcount_q} + 9'd1) < {1'b0, de_q}) begin
                        state_d = GAP;
                    end else begin
                        state_d = FLOOR;
                    end
                end
            end
            GAP: begin
                // One idle cycle so the next request is a fresh edge.
                state_d = REQ;
            end
            FLOOR: begin
                if (vcount_q < H8) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = addr_q;
                    fb_data_d = FLOOR_COLOR;
                    vcount_d  = vcount_q + 8'd1;
                    addr_d    = addr_q + WSTR;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            vcount_q  <= '0;
            addr_q    <= '0;
            ds_q      <= '0;
            de_q      <= '0;
            wallx_q   <= '0;
            lh_q      <= '0;
            dstart_q  <= '0;
            tex_q     <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            vcount_q  <= vcount_d;
            addr_q    <= addr_d;
            ds_q      <= ds_d;
            de_q      <= de_d;
            wallx_q   <= wallx_d;
            lh_q      <= lh_d;
            dstart_q  <= dstart_d;
            tex_q     <= tex_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
        end
    end

    assign io.col_ready_out  = (state_q == IDLE);
    assign io.valid_req_out  = (state_q == REQ) || (state_q == WAIT);
    assign io.vcount_ray_out = io.valid_req_out ? vcount_q : '0;
    assign io.col_done_out   = (state_q == DONE);
    assign io.wallX_out      = wallx_q;
    assign io.lineheight_out = lh_q;
    assign io.drawstart_out  = dstart_q;
    assign io.texture_out    = tex_q;
    assign io.fb_we_out      = fb_we_q;
    assign io.fb_addr_out    = fb_addr_q;
    assign io.fb_data_out    = fb_data_q;

endmodule
